// File: rtl/shifter_normalizer_32bit.sv
// Multi-cycle 32-bit normalizer: strips redundant leading sign bits (SIGNED=1) or
// leading zeros (SIGNED=0) with a 16/8/4/2/1 binary search, one stage per cycle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | applying stage k = 4..0, one per clock
// DONE  | result held with out_valid high until out_ready
module shifter_normalizer_32bit #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d_out,
    output logic [4:0]  sh_amt,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [31:0] data_reg;
    logic [2:0]  stage;
    logic        hit;
    logic [31:0] shifted;

    // Signed mode keeps one extra bit in the test window so the sign survives the shift.
    always_comb begin
        hit     = 1'b0;
        shifted = data_reg;
        case (stage)
            3'd4: begin
                hit     = SIGNED ? ((&data_reg[31:15]) | ~(|data_reg[31:15])) : ~(|data_reg[31:16]);
                shifted = data_reg << 16;
            end
            3'd3: begin
                hit     = SIGNED ? ((&data_reg[31:23]) | ~(|data_reg[31:23])) : ~(|data_reg[31:24]);
                shifted = data_reg << 8;
            end
            3'd2: begin
                hit     = SIGNED ? ((&data_reg[31:27]) | ~(|data_reg[31:27])) : ~(|data_reg[31:28]);
                shifted = data_reg << 4;
            end
            3'd1: begin
                hit     = SIGNED ? ((&data_reg[31:29]) | ~(|data_reg[31:29])) : ~(|data_reg[31:30]);
                shifted = data_reg << 2;
            end
            default: begin
                hit     = SIGNED ? (data_reg[31] == data_reg[30]) : ~data_reg[31];
                shifted = data_reg << 1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            data_reg  <= '0;
            stage     <= 3'd0;
            sh_amt    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= d_in;
                        sh_amt   <= '0;
                        zero     <= (d_in == 32'd0);
                        stage    <= 3'd4;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hit) begin
                        data_reg <= shifted;
                    end
                    sh_amt[stage] <= hit;
                    if (stage == 3'd0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        stage <= stage - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign d_out = data_reg;

endmodule
